// File: rtl/debug_ocimem_arbiter_if.sv
// debug_ocimem_arbiter_if: CPU slave bus and single-port OCI RAM bus seen by the arbiter
interface debug_ocimem_arbiter_if #(parameter int ADDR_W = 8);
  logic [ADDR_W-1:0] cpu_address;
  logic              cpu_read;
  logic              cpu_write;
  logic [31:0]       cpu_writedata;
  logic [31:0]       cpu_readdata;
  logic              cpu_waitrequest;
  logic [ADDR_W-1:0] ram_address;
  logic              ram_wren;
  logic [31:0]       ram_wrdata;
  logic [31:0]       ram_rddata;
  modport master (
    output cpu_address, cpu_read, cpu_write, cpu_writedata, ram_rddata,
    input  cpu_readdata, cpu_waitrequest, ram_address, ram_wren, ram_wrdata
  );
  modport slave (
    input  cpu_address, cpu_read, cpu_write, cpu_writedata, ram_rddata,
    output cpu_readdata, cpu_waitrequest, ram_address, ram_wren, ram_wrdata
  );
endinterface

// File: rtl/debug_ocimem_arbiter.sv
// debug_ocimem_arbiter: round-robin sharing of the OCI RAM between JTAG monitor commands and the CPU
module debug_ocimem_arbiter #(
  parameter int ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [37:0]           jdo,
  input  logic                  take_action_ocimem_a,
  input  logic                  take_no_action_ocimem_a,
  input  logic                  take_action_ocimem_b,
  debug_ocimem_arbiter_if.slave bus,
  output logic [ADDR_W-1:0]     MonAReg,
  output logic [31:0]           MonDReg,
  output logic                  jtag_pending,
  output logic                  jtag_overrun
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD_J = 2'd1;
  localparam logic [1:0] RD_C = 2'd2;
  logic [1:0]        state;
  logic              pend_wr;
  logic              last_cpu;
  logic [ADDR_W-1:0] pend_addr;
  logic [31:0]       pend_data;
  logic              idle;
  logic              cpu_req;
  logic              grant_j;
  logic              grant_c;
  logic              rd_done;
  logic              pulse;
  logic              accept;
  logic [ADDR_W-1:0] inc_addr;
  logic [ADDR_W-1:0] jdo_addr;
  logic              unused_jdo;
  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};
  // Arbitration, RAM port steering and CPU handshake; reset blocks any issue or completion
  always_comb begin
    idle                = state == IDLE && !reset;
    cpu_req             = bus.cpu_read || bus.cpu_write;
    grant_j             = idle && jtag_pending && (!cpu_req || last_cpu);
    grant_c             = idle && cpu_req && !grant_j;
    rd_done             = state == RD_C && !reset;
    bus.ram_address     = grant_j ? pend_addr : bus.cpu_address;
    bus.ram_wren        = (grant_j && pend_wr) || (grant_c && bus.cpu_write);
    bus.ram_wrdata      = grant_j ? pend_data : bus.cpu_writedata;
    bus.cpu_readdata    = rd_done ? bus.ram_rddata : 32'h0;
    bus.cpu_waitrequest = cpu_req && !(rd_done || (grant_c && bus.cpu_write));
    inc_addr            = MonAReg + ADDR_W'(1);
    jdo_addr            = jdo[ADDR_W+16:17];
    pulse               = take_action_ocimem_a || take_no_action_ocimem_a || take_action_ocimem_b;
    accept              = pulse && (!jtag_pending || grant_j);
  end
  // FSM, round-robin history, one-deep JTAG command slot and monitor registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      last_cpu     <= 1'b1;
      MonAReg      <= '0;
      MonDReg      <= '0;
      jtag_pending <= 1'b0;
      jtag_overrun <= 1'b0;
      pend_wr      <= 1'b0;
      pend_addr    <= '0;
      pend_data    <= '0;
    end else begin
      state <= grant_j && !pend_wr ? RD_J : grant_c && !bus.cpu_write ? RD_C : IDLE;
      if (grant_j || grant_c) last_cpu <= grant_c;
      if (state == RD_J) MonDReg <= bus.ram_rddata;
      else if (grant_j && pend_wr) MonDReg <= pend_data;
      if (grant_j) jtag_pending <= 1'b0;
      if (accept) begin
        jtag_pending <= 1'b1;
        pend_wr      <= take_action_ocimem_b;
        pend_addr    <= take_action_ocimem_b ? MonAReg : take_action_ocimem_a ? jdo_addr : inc_addr;
        pend_data    <= jdo[34:3];
        MonAReg      <= !take_action_ocimem_b && take_action_ocimem_a ? jdo_addr : inc_addr;
      end
      if (pulse && !accept) jtag_overrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_debug_ocimem_arbiter.sv
// tb_debug_ocimem_arbiter: vector table plus JTAG/CPU corner sequences with a read-data scoreboard
module tb_debug_ocimem_arbiter;
  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] data;
    int          waits;
  } vec_t;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [37:0] jdo = '0;
  logic        ta_a = 1'b0;
  logic        tna_a = 1'b0;
  logic        ta_b = 1'b0;
  logic [7:0]  mon_a;
  logic [31:0] mon_d;
  logic        pending;
  logic        overrun;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem [256];
  logic [31:0] exp_q [$];
  vec_t        vec [10];
  logic [7:0]  alt_addr [5];
  logic        alt_wait [5];
  debug_ocimem_arbiter_if #(.ADDR_W(8)) bif();
  debug_ocimem_arbiter #(.ADDR_W(8)) dut (
    .clk(clk),
    .reset(reset),
    .jdo(jdo),
    .take_action_ocimem_a(ta_a),
    .take_no_action_ocimem_a(tna_a),
    .take_action_ocimem_b(ta_b),
    .bus(bif),
    .MonAReg(mon_a),
    .MonDReg(mon_d),
    .jtag_pending(pending),
    .jtag_overrun(overrun)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bif.ram_wren) mem[bif.ram_address] <= bif.ram_wrdata;
    bif.ram_rddata <= mem[bif.ram_address];
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic sb_pop(input string name, input logic [31:0] act);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got %h expected a queued value but queue is empty", name, act);
    end else chk(name, act, exp_q.pop_front());
  endtask
  task automatic cpu_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] data, input int exp_waits);
    int waits = 0;
    bif.cpu_read = !wr;
    bif.cpu_write = wr;
    bif.cpu_address = addr;
    bif.cpu_writedata = data;
    if (!wr) exp_q.push_back(data);
    #1;
    while (bif.cpu_waitrequest && waits < 20) begin
      tick();
      #1;
      waits++;
    end
    chk("cpu_waits", 32'(waits), 32'(exp_waits));
    if (!wr) sb_pop("cpu_readdata", bif.cpu_readdata);
    tick();
    bif.cpu_read = 1'b0;
    bif.cpu_write = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
  initial begin
    vec[0] = '{1'b1, 8'h04, 32'hA5A5A5A5, 0};
    vec[1] = '{1'b1, 8'h10, 32'hDEADBEEF, 0};
    vec[2] = '{1'b1, 8'hFF, 32'h11111111, 0};
    vec[3] = '{1'b1, 8'h00, 32'hCAFEF00D, 0};
    vec[4] = '{1'b0, 8'h04, 32'hA5A5A5A5, 1};
    vec[5] = '{1'b0, 8'h10, 32'hDEADBEEF, 1};
    vec[6] = '{1'b0, 8'hFF, 32'h11111111, 1};
    vec[7] = '{1'b0, 8'h00, 32'hCAFEF00D, 1};
    vec[8] = '{1'b1, 8'h04, 32'hA5A5A5A5, 0};
    vec[9] = '{1'b0, 8'h04, 32'hA5A5A5A5, 1};
    alt_addr = '{8'h30, 8'h01, 8'h30, 8'h02, 8'h30};
    alt_wait = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    bif.cpu_read = 1'b0;
    bif.cpu_write = 1'b0;
    bif.cpu_address = '0;
    bif.cpu_writedata = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_MonAReg", 32'(mon_a), 32'h0);
    chk("rst_MonDReg", mon_d, 32'h0);
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    chk("rst_ram_wren", 32'(bif.ram_wren), 32'h0);
    chk("rst_cpu_readdata", bif.cpu_readdata, 32'h0);
    chk("rst_waitrequest", 32'(bif.cpu_waitrequest), 32'h0);
    for (int i = 0; i < 10; i++) cpu_xfer(vec[i].wr, vec[i].addr, vec[i].data, vec[i].waits);
    jdo = '0;
    jdo[24:17] = 8'h10;
    ta_a = 1'b1;
    tick();
    ta_a = 1'b0;
    #1;
    chk("jrd_MonAReg", 32'(mon_a), 32'h10);
    chk("jrd_pending", 32'(pending), 32'h1);
    chk("jrd_ram_address", 32'(bif.ram_address), 32'h10);
    chk("jrd_ram_wren", 32'(bif.ram_wren), 32'h0);
    tick();
    tick();
    chk("jrd_MonDReg", mon_d, 32'hDEADBEEF);
    chk("jrd_pending_clr", 32'(pending), 32'h0);
    jdo = '0;
    jdo[24:17] = 8'hFF;
    ta_a = 1'b1;
    tick();
    ta_a = 1'b0;
    tick();
    tick();
    chk("jrd_ff_MonDReg", mon_d, 32'h11111111);
    jdo = '0;
    jdo[34:3] = 32'h12345678;
    ta_b = 1'b1;
    tick();
    ta_b = 1'b0;
    #1;
    chk("jwr_MonAReg_wrap", 32'(mon_a), 32'h0);
    chk("jwr_pending", 32'(pending), 32'h1);
    chk("jwr_ram_wren", 32'(bif.ram_wren), 32'h1);
    chk("jwr_ram_address", 32'(bif.ram_address), 32'hFF);
    chk("jwr_ram_wrdata", bif.ram_wrdata, 32'h12345678);
    tick();
    #1;
    chk("jwr_ram_wren_off", 32'(bif.ram_wren), 32'h0);
    chk("jwr_MonDReg", mon_d, 32'h12345678);
    cpu_xfer(1'b0, 8'hFF, 32'h12345678, 1);
    bif.cpu_read = 1'b1;
    bif.cpu_write = 1'b1;
    bif.cpu_address = 8'h40;
    bif.cpu_writedata = 32'h77;
    #1;
    chk("rw_both_wait", 32'(bif.cpu_waitrequest), 32'h0);
    chk("rw_both_wren", 32'(bif.ram_wren), 32'h1);
    tick();
    bif.cpu_read = 1'b0;
    bif.cpu_write = 1'b0;
    cpu_xfer(1'b0, 8'h40, 32'h77, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    jdo = '0;
    jdo[34:3] = 32'h0BADF00D;
    ta_b = 1'b1;
    tick();
    ta_b = 1'b0;
    bif.cpu_write = 1'b1;
    bif.cpu_address = 8'h20;
    bif.cpu_writedata = 32'h55;
    #1;
    chk("tie_ram_address", 32'(bif.ram_address), 32'h0);
    chk("tie_ram_wren", 32'(bif.ram_wren), 32'h1);
    chk("tie_cpu_wait", 32'(bif.cpu_waitrequest), 32'h1);
    tick();
    #1;
    chk("tie2_ram_address", 32'(bif.ram_address), 32'h20);
    chk("tie2_ram_wrdata", bif.ram_wrdata, 32'h55);
    chk("tie2_cpu_wait", 32'(bif.cpu_waitrequest), 32'h0);
    tick();
    bif.cpu_address = 8'h30;
    bif.cpu_writedata = 32'h66;
    jdo = '0;
    jdo[34:3] = 32'hC1;
    ta_b = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("alt_ram_address", 32'(bif.ram_address), 32'(alt_addr[k]));
      chk("alt_cpu_wait", 32'(bif.cpu_waitrequest), 32'(alt_wait[k]));
      tick();
      if (k == 0) jdo[34:3] = 32'hC2;
      if (k == 1) ta_b = 1'b0;
    end
    bif.cpu_write = 1'b0;
    chk("alt_overrun", 32'(overrun), 32'h0);
    chk("alt_MonAReg", 32'(mon_a), 32'h3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bif.cpu_read = 1'b1;
    bif.cpu_address = 8'h04;
    exp_q.push_back(32'hA5A5A5A5);
    tna_a = 1'b1;
    #1;
    chk("ovr_cpu_wait", 32'(bif.cpu_waitrequest), 32'h1);
    tick();
    #1;
    chk("ovr_pending", 32'(pending), 32'h1);
    chk("ovr_cpu_done", 32'(bif.cpu_waitrequest), 32'h0);
    sb_pop("ovr_cpu_readdata", bif.cpu_readdata);
    tick();
    tna_a = 1'b0;
    bif.cpu_read = 1'b0;
    #1;
    chk("ovr_overrun", 32'(overrun), 32'h1);
    chk("ovr_ram_address", 32'(bif.ram_address), 32'h1);
    chk("ovr_ram_wren", 32'(bif.ram_wren), 32'h0);
    tick();
    tick();
    chk("ovr_MonDReg", mon_d, 32'hC1);
    chk("ovr_MonAReg", 32'(mon_a), 32'h1);
    chk("ovr_pending_clr", 32'(pending), 32'h0);
    bif.cpu_read = 1'b1;
    bif.cpu_address = 8'h10;
    #1;
    chk("rstrd_wait", 32'(bif.cpu_waitrequest), 32'h1);
    tick();
    reset = 1'b1;
    #1;
    chk("rstrd_readdata", bif.cpu_readdata, 32'h0);
    chk("rstrd_wait_held", 32'(bif.cpu_waitrequest), 32'h1);
    tick();
    reset = 1'b0;
    #1;
    chk("rstrd_overrun_clr", 32'(overrun), 32'h0);
    chk("rstrd_MonDReg", mon_d, 32'h0);
    chk("rstrd_reissue_addr", 32'(bif.ram_address), 32'h10);
    chk("rstrd_reissue_wait", 32'(bif.cpu_waitrequest), 32'h1);
    exp_q.push_back(32'hDEADBEEF);
    tick();
    #1;
    chk("rstrd_done_wait", 32'(bif.cpu_waitrequest), 32'h0);
    sb_pop("rstrd_readdata_ok", bif.cpu_readdata);
    tick();
    bif.cpu_read = 1'b0;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
